// File: rtl/sga_move_scheduler_if.sv
// Signal bundle between the move scheduler, the control unit and the game datapath.
interface sga_move_scheduler_if;
    // control unit / player inputs
    logic       restart;
    logic       enable;
    logic [3:0] buttons;
    // datapath status
    logic [3:0] size;
    logic       render_finish;
    logic       is_at_apple;
    logic       is_at_border;
    logic       is_at_body;
    // datapath strobes and status outputs
    logic       render_clr;
    logic       render_count;
    logic       step;
    logic       count_size;
    logic       register_apple;
    logic       full;
    logic       collision;
    logic [1:0] direction;
    logic [3:0] db_state;

    // Scheduler side
    modport master (
        input  restart, enable, buttons, size, render_finish,
               is_at_apple, is_at_border, is_at_body,
        output render_clr, render_count, step, count_size,
               register_apple, full, collision, direction, db_state
    );

    // Control unit / datapath side
    modport slave (
        output restart, enable, buttons, size, render_finish,
               is_at_apple, is_at_border, is_at_body,
        input  render_clr, render_count, step, count_size,
               register_apple, full, collision, direction, db_state
    );
endinterface

// File: rtl/sga_move_scheduler.sv
// Snake move scheduler: waits one tick, latches the heading, runs the render
// sweep, commits one head step and judges the datapath comparators.
module sga_move_scheduler #(
    parameter int unsigned TICK_CYCLES = 25_000_000,
    parameter int unsigned TICK_W      = 25
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sga_move_scheduler_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WAIT    = 4'd1,
        S_LATCH   = 4'd2,
        S_CLR     = 4'd3,
        S_RENDER  = 4'd4,
        S_MOVE    = 4'd5,
        S_CHECK   = 4'd6,
        S_GROW    = 4'd7,
        S_COLLIDE = 4'd8
    } state_t;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [3:0]        SIZE_MAX  = 4'd15;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic [1:0]        dir_q, dir_d;
    logic [1:0]        pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic [1:0]        btn_dir;

    logic render_clr_q;
    logic render_count_q;
    logic step_q;
    logic count_size_q;
    logic register_apple_q;
    logic full_q;
    logic collision_q;

    // Button priority encoder: up > down > left > right.
    always_comb begin
        btn_dir = DIR_RIGHT;
        if (bus.buttons[0]) begin
            btn_dir = DIR_UP;
        end else if (bus.buttons[1]) begin
            btn_dir = DIR_DOWN;
        end else if (bus.buttons[2]) begin
            btn_dir = DIR_LEFT;
        end
    end

    // Next-state, tick counter, heading and pending-request logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.enable) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.enable) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == TICK_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LATCH;
                end else begin
                    cnt_d = cnt_q + TICK_W'(1);
                end
            end
            S_LATCH: begin
                // A request pointing straight back into the body is dropped.
                if (pend_v_q && (pend_q != (dir_q ^ 2'b01))) begin
                    dir_d = pend_q;
                end
                pend_v_d = 1'b0;
                state_d  = S_CLR;
            end
            S_CLR: begin
                state_d = S_RENDER;
            end
            S_RENDER: begin
                if (bus.render_finish) begin
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (bus.is_at_border || bus.is_at_body) begin
                    state_d = S_COLLIDE;
                end else if (bus.is_at_apple) begin
                    state_d = S_GROW;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GROW: begin
                state_d = S_WAIT;
            end
            S_COLLIDE: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A press during LATCH is kept for the next move rather than lost.
        if ((state_q != S_IDLE) && (state_q != S_COLLIDE) && (bus.buttons != '0)) begin
            pend_d   = btn_dir;
            pend_v_d = 1'b1;
        end
    end

    // State registers; strobes are decoded from the next state so they are
    // registered and line up exactly with the cycle spent in each state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            dir_q            <= DIR_RIGHT;
            pend_q           <= DIR_RIGHT;
            pend_v_q         <= 1'b0;
            render_clr_q     <= 1'b0;
            render_count_q   <= 1'b0;
            step_q           <= 1'b0;
            count_size_q     <= 1'b0;
            register_apple_q <= 1'b0;
            full_q           <= 1'b0;
            collision_q      <= 1'b0;
        end else if (bus.restart) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            dir_q            <= DIR_RIGHT;
            pend_q           <= DIR_RIGHT;
            pend_v_q         <= 1'b0;
            render_clr_q     <= 1'b0;
            render_count_q   <= 1'b0;
            step_q           <= 1'b0;
            count_size_q     <= 1'b0;
            register_apple_q <= 1'b0;
            full_q           <= 1'b0;
            collision_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            dir_q            <= dir_d;
            pend_q           <= pend_d;
            pend_v_q         <= pend_v_d;
            render_clr_q     <= (state_d == S_CLR);
            render_count_q   <= (state_d == S_RENDER);
            step_q           <= (state_d == S_MOVE);
            count_size_q     <= (state_d == S_GROW) && (bus.size != SIZE_MAX);
            register_apple_q <= (state_d == S_GROW);
            full_q           <= (state_d == S_GROW) && (bus.size == SIZE_MAX);
            collision_q      <= (state_d == S_COLLIDE);
        end
    end

    assign bus.render_clr     = render_clr_q;
    // The sweep must not advance in the cycle the datapath reports completion.
    assign bus.render_count   = render_count_q & ~bus.render_finish;
    assign bus.step           = step_q;
    assign bus.count_size     = count_size_q;
    assign bus.register_apple = register_apple_q;
    assign bus.full           = full_q;
    assign bus.collision      = collision_q;
    assign bus.direction      = dir_q;
    assign bus.db_state       = state_q;

endmodule

// File: tb/tb_sga_move_scheduler.sv
// Table-driven bench for sga_move_scheduler with TICK_CYCLES=4 and a
// datapath model that finishes the render sweep on its 3rd RENDER cycle.
module tb_sga_move_scheduler;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_WAIT    = 4'd1;
    localparam logic [3:0] ST_LATCH   = 4'd2;
    localparam logic [3:0] ST_CLR     = 4'd3;
    localparam logic [3:0] ST_RENDER  = 4'd4;
    localparam logic [3:0] ST_MOVE    = 4'd5;
    localparam logic [3:0] ST_CHECK   = 4'd6;
    localparam logic [3:0] ST_GROW    = 4'd7;
    localparam logic [3:0] ST_COLLIDE = 4'd8;

    // {render_clr, render_count, step, count_size, register_apple, full, collision}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_CLR  = 7'b1000000;
    localparam logic [6:0] O_CNT  = 7'b0100000;
    localparam logic [6:0] O_STEP = 7'b0010000;
    localparam logic [6:0] O_GROW = 7'b0001100;
    localparam logic [6:0] O_FULL = 7'b0000110;
    localparam logic [6:0] O_COL  = 7'b0000001;

    localparam int RENDER_LEN = 3;

    typedef struct packed {
        logic       en;
        logic [3:0] btn;
        logic [2:0] cmp;  // {apple, border, body}
        logic [3:0] sz;
        logic [3:0] st;
        logic [6:0] o;
        logic [1:0] d;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   rcnt;
    vec_t vecs[$];

    sga_move_scheduler_if bus();

    sga_move_scheduler #(
        .TICK_CYCLES(4),
        .TICK_W     (3)
    ) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic en, input logic [3:0] btn, input logic [2:0] cmp,
                                input logic [3:0] sz, input logic [3:0] st, input logic [6:0] o,
                                input logic [1:0] d);
        vec_t v;
        v.en  = en;
        v.btn = btn;
        v.cmp = cmp;
        v.sz  = sz;
        v.st  = st;
        v.o   = o;
        v.d   = d;
        vecs.push_back(v);
    endfunction

    function automatic logic [6:0] outs();
        return {bus.render_clr, bus.render_count, bus.step, bus.count_size,
                bus.register_apple, bus.full, bus.collision};
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    // One clock: edge, datapath render model update, then settle for sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.db_state == ST_RENDER) begin
            rcnt++;
            bus.render_finish = (rcnt >= RENDER_LEN);
        end else begin
            rcnt = 0;
            bus.render_finish = 1'b0;
        end
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rcnt     = 0;
        rst_n    = 1'b0;
        bus.restart       = 1'b0;
        bus.enable        = 1'b0;
        bus.buttons       = 4'b0000;
        bus.size          = 4'd3;
        bus.render_finish = 1'b0;
        bus.is_at_apple   = 1'b0;
        bus.is_at_border  = 1'b0;
        bus.is_at_body    = 1'b0;

        // Normal moves, direction handling, apple growth and full.
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b00);  // 0
        add(1, 4'b0100, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b00);  // press left
        add(1, 4'b0001, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b00);  // then up
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b00);
        add(1, 4'b0000, 3'b000, 3,  ST_LATCH,   O_NONE, 2'b00);  // 4
        add(1, 4'b0000, 3'b000, 3,  ST_CLR,     O_CLR,  2'b10);
        add(1, 4'b0000, 3'b000, 3,  ST_RENDER,  O_CNT,  2'b10);
        add(1, 4'b0000, 3'b000, 3,  ST_RENDER,  O_CNT,  2'b10);
        add(1, 4'b0000, 3'b000, 3,  ST_RENDER,  O_NONE, 2'b10);  // finish
        add(1, 4'b0000, 3'b000, 3,  ST_MOVE,    O_STEP, 2'b10);
        add(1, 4'b0000, 3'b000, 3,  ST_CHECK,   O_NONE, 2'b10);  // 10
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b10);
        add(1, 4'b0100, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b10);  // press left
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b10);
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b10);
        add(1, 4'b0000, 3'b000, 3,  ST_LATCH,   O_NONE, 2'b10);  // 15: period 11
        add(1, 4'b0000, 3'b000, 3,  ST_CLR,     O_CLR,  2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_RENDER,  O_CNT,  2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_RENDER,  O_CNT,  2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_RENDER,  O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_MOVE,    O_STEP, 2'b01);  // 20
        add(1, 4'b0000, 3'b000, 3,  ST_CHECK,   O_NONE, 2'b01);
        add(1, 4'b0000, 3'b100, 3,  ST_GROW,    O_GROW, 2'b01);  // apple, size 3
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);
        add(1, 4'b1000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);  // press right
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);  // 25
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_LATCH,   O_NONE, 2'b01);  // period 12
        add(1, 4'b0000, 3'b000, 15, ST_CLR,     O_CLR,  2'b01);  // reversal rejected
        add(1, 4'b0000, 3'b000, 15, ST_RENDER,  O_CNT,  2'b01);
        add(1, 4'b0000, 3'b000, 15, ST_RENDER,  O_CNT,  2'b01);  // 30
        add(1, 4'b0000, 3'b000, 15, ST_RENDER,  O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 15, ST_MOVE,    O_STEP, 2'b01);
        add(1, 4'b0000, 3'b000, 15, ST_CHECK,   O_NONE, 2'b01);
        add(1, 4'b0000, 3'b100, 15, ST_GROW,    O_FULL, 2'b01);  // apple, size 15
        // Pause mid-WAIT, then confirm the counter restarted from 0.
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);  // 35
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);
        add(0, 4'b0000, 3'b000, 3,  ST_IDLE,    O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);  // 40
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_LATCH,   O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_CLR,     O_CLR,  2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_RENDER,  O_CNT,  2'b01);
        // Pause during RENDER: sweep, step and check still complete.
        add(0, 4'b0000, 3'b000, 3,  ST_RENDER,  O_CNT,  2'b01);  // 45
        add(0, 4'b0000, 3'b000, 3,  ST_RENDER,  O_NONE, 2'b01);
        add(0, 4'b0000, 3'b000, 3,  ST_MOVE,    O_STEP, 2'b01);
        add(0, 4'b0000, 3'b000, 3,  ST_CHECK,   O_NONE, 2'b01);
        add(0, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);
        add(0, 4'b0000, 3'b000, 3,  ST_IDLE,    O_NONE, 2'b01);  // 50
        // Body and apple together: collision wins.
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_WAIT,    O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_LATCH,   O_NONE, 2'b01);  // 55
        add(1, 4'b0000, 3'b000, 3,  ST_CLR,     O_CLR,  2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_RENDER,  O_CNT,  2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_RENDER,  O_CNT,  2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_RENDER,  O_NONE, 2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_MOVE,    O_STEP, 2'b01);  // 60
        add(1, 4'b0000, 3'b000, 3,  ST_CHECK,   O_NONE, 2'b01);
        add(1, 4'b0000, 3'b101, 3,  ST_COLLIDE, O_COL,  2'b01);
        add(1, 4'b0000, 3'b000, 3,  ST_COLLIDE, O_COL,  2'b01);
        add(0, 4'b0000, 3'b000, 3,  ST_IDLE,    O_NONE, 2'b01);

        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("reset_state", -1, 16'(bus.db_state), 16'(ST_IDLE));
        chk("reset_outs",  -1, 16'(outs()),       16'(O_NONE));
        chk("reset_dir",   -1, 16'(bus.direction), 16'(2'b00));

        for (int i = 0; i < vecs.size(); i++) begin
            bus.enable       = vecs[i].en;
            bus.buttons      = vecs[i].btn;
            bus.is_at_apple  = vecs[i].cmp[2];
            bus.is_at_border = vecs[i].cmp[1];
            bus.is_at_body   = vecs[i].cmp[0];
            bus.size         = vecs[i].sz;
            cyc();
            chk("state", i, 16'(bus.db_state),  16'(vecs[i].st));
            chk("outs",  i, 16'(outs()),        16'(vecs[i].o));
            chk("dir",   i, 16'(bus.direction), 16'(vecs[i].d));
        end
        bus.buttons      = 4'b0000;
        bus.is_at_apple  = 1'b0;
        bus.is_at_border = 1'b0;
        bus.is_at_body   = 1'b0;
        bus.size         = 4'd3;

        // Border hit, then restart from COLLIDE with enable still high.
        bus.enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (bus.db_state == ST_CHECK) break;
        end
        chk("reach_check", 0, 16'(bus.db_state), 16'(ST_CHECK));
        bus.is_at_border = 1'b1;
        cyc();
        bus.is_at_border = 1'b0;
        chk("border_state", 0, 16'(bus.db_state), 16'(ST_COLLIDE));
        chk("border_coll",  0, 16'(bus.collision), 16'(1'b1));
        chk("border_dir",   0, 16'(bus.direction), 16'(2'b01));
        bus.restart = 1'b1;
        cyc();
        bus.restart = 1'b0;
        chk("restart_state", 0, 16'(bus.db_state),  16'(ST_IDLE));
        chk("restart_outs",  0, 16'(outs()),        16'(O_NONE));
        chk("restart_dir",   0, 16'(bus.direction), 16'(2'b00));

        // Press down after restart (heading right, so not a reversal),
        // then async reset in the middle of RENDER.
        cyc();
        chk("rerun_state", 0, 16'(bus.db_state), 16'(ST_WAIT));
        bus.buttons = 4'b0010;
        cyc();
        bus.buttons = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (bus.db_state == ST_RENDER) break;
        end
        chk("reach_render", 0, 16'(bus.db_state),  16'(ST_RENDER));
        chk("render_dir",   0, 16'(bus.direction), 16'(2'b11));
        chk("render_outs",  0, 16'(outs()),        16'(O_CNT));
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_state", 0, 16'(bus.db_state),  16'(ST_IDLE));
        chk("areset_outs",  0, 16'(outs()),        16'(O_NONE));
        chk("areset_dir",   0, 16'(bus.direction), 16'(2'b00));
        bus.enable = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_reset_state", 0, 16'(bus.db_state), 16'(ST_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
